// File: rtl/event_mon_pkg.sv
// -----------------------------------------------------------------------------
// event_mon_pkg
// Shared definitions for the event pulse monitor:
//   - state_t and the four FSM state encodings (IDLE, ACQUIRE, TRACK, LOCKED)
//   - ERRCNT_W, width of the saturating error total
//   - errcnt_sat_inc(), saturating increment for the error total
// -----------------------------------------------------------------------------
package event_mon_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACQUIRE = 2'd1;
  localparam state_t ST_TRACK   = 2'd2;
  localparam state_t ST_LOCKED  = 2'd3;

  localparam int ERRCNT_W = 8;

  // Saturating +1 for the error total: sticks at all-ones instead of wrapping.
  function automatic logic [ERRCNT_W-1:0] errcnt_sat_inc(input logic [ERRCNT_W-1:0] val);
    logic [ERRCNT_W-1:0] res;
    if (val == {ERRCNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/event_interval_counter.sv
// -----------------------------------------------------------------------------
// event_interval_counter
// WIDTH-bit saturating up-counter measuring clocks since the last pulse.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (counter -> 0)
//   clr    - synchronous clear to 0 (highest priority)
//   load   - synchronous load of 1 (edge that samples a pulse)
//   cnt    - registered count, saturates at 2^WIDTH-1
// -----------------------------------------------------------------------------
module event_interval_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_r;

  // Interval register: clear, load-1, or saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= CNT_ONE;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/event_pulse_monitor.sv
// -----------------------------------------------------------------------------
// event_pulse_monitor
// Health monitor for a periodic one-cycle tick. Measures the spacing between
// pulses, locks after LOCK_CNT consecutive in-range periods, flags early and
// late (missing) pulses for one cycle and drops lock on any error.
//
// Parameters:
//   N        - expected period in clk cycles (N >= 2)
//   TOL      - allowed deviation; valid period is [N-TOL, N+TOL]
//   LOCK_CNT - consecutive valid periods required for lock
//   WIDTH    - interval counter width, N+TOL+1 <= 2^WIDTH-1
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   enable      - monitor enable, low forces IDLE
//   event_pulse - pulse under test, synchronous to clk
//   locked      - high while in LOCKED
//   err_early   - one-cycle flag, pulse before N-TOL
//   err_late    - one-cycle flag, no pulse by N+TOL
//   last_period - most recently measured period
//   err_count   - saturating error total
//
// Build option: define EVENT_MON_ERR_COUNT_EN to build the error total;
// otherwise err_count is tied to 0 and everything else is unchanged.
// -----------------------------------------------------------------------------
module event_pulse_monitor
  import event_mon_pkg::*;
#(
  parameter int N        = 10,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int WIDTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                event_pulse,
  output logic                locked,
  output logic                err_early,
  output logic                err_late,
  output logic [WIDTH-1:0]    last_period,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] LO_LIM = WIDTH'(N - TOL);
  localparam logic [WIDTH-1:0] HI_LIM = WIDTH'(N + TOL);

  // Good-run counter only needs to reach LOCK_CNT; it saturates there.
  localparam int                GOOD_W    = $clog2(LOCK_CNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = {{(GOOD_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [GOOD_W-1:0] good_r;
  logic [GOOD_W-1:0] good_nxt_s;
  logic [GOOD_W-1:0] good_inc_s;
  logic [WIDTH-1:0]  cnt_s;
  logic              cnt_clr_s;
  logic              cnt_load_s;
  logic              early_s;
  logic              late_s;
  logic              period_upd_s;

  logic              locked_r;
  logic              err_early_r;
  logic              err_late_r;
  logic [WIDTH-1:0]  last_period_r;

  event_interval_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .load  (cnt_load_s),
    .cnt   (cnt_s)
  );

  // Saturating next value of the good-run counter.
  always_comb begin
    if (good_r >= GOOD_LOCK) begin
      good_inc_s = good_r;
    end else begin
      good_inc_s = good_r + GOOD_ONE;
    end
  end

  // FSM next state, interval checks and counter controls.
  always_comb begin
    state_nxt_s  = state_r;
    good_nxt_s   = good_r;
    cnt_clr_s    = 1'b0;
    cnt_load_s   = 1'b0;
    early_s      = 1'b0;
    late_s       = 1'b0;
    period_upd_s = 1'b0;

    if (!enable) begin
      // Disable wins over any pulse or timeout in the same cycle.
      state_nxt_s = ST_IDLE;
      good_nxt_s  = {GOOD_W{1'b0}};
      cnt_clr_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_ACQUIRE;
          good_nxt_s  = {GOOD_W{1'b0}};
          cnt_clr_s   = 1'b1;
        end

        ST_ACQUIRE: begin
          // First pulse only establishes the timing reference.
          if (event_pulse) begin
            cnt_load_s  = 1'b1;
            good_nxt_s  = {GOOD_W{1'b0}};
            state_nxt_s = ST_TRACK;
          end else begin
            state_nxt_s = ST_ACQUIRE;
          end
        end

        ST_TRACK, ST_LOCKED: begin
          if (event_pulse) begin
            if (cnt_s < LO_LIM) begin
              early_s      = 1'b1;
              period_upd_s = 1'b1;
              cnt_load_s   = 1'b1;
              good_nxt_s   = {GOOD_W{1'b0}};
              state_nxt_s  = ST_TRACK;
            end else if (cnt_s <= HI_LIM) begin
              // A pulse exactly at N+TOL is in range, not late.
              period_upd_s = 1'b1;
              cnt_load_s   = 1'b1;
              good_nxt_s   = good_inc_s;
              if ((state_r == ST_TRACK) && (good_inc_s >= GOOD_LOCK)) begin
                state_nxt_s = ST_LOCKED;
              end else begin
                state_nxt_s = state_r;
              end
            end else begin
              // Beyond N+TOL cannot normally be reached because the timeout
              // below fires first; treat it as late and re-acquire.
              late_s      = 1'b1;
              good_nxt_s  = {GOOD_W{1'b0}};
              state_nxt_s = ST_ACQUIRE;
            end
          end else if (cnt_s >= HI_LIM) begin
            late_s      = 1'b1;
            good_nxt_s  = {GOOD_W{1'b0}};
            state_nxt_s = ST_ACQUIRE;
          end else begin
            state_nxt_s = state_r;
          end
        end

        default: begin
          state_nxt_s = ST_IDLE;
          good_nxt_s  = {GOOD_W{1'b0}};
          cnt_clr_s   = 1'b1;
        end
      endcase
    end
  end

  // State, good-run counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      good_r        <= {GOOD_W{1'b0}};
      locked_r      <= 1'b0;
      err_early_r   <= 1'b0;
      err_late_r    <= 1'b0;
      last_period_r <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      good_r      <= good_nxt_s;
      // Derived from the next state so lock tracks the state with no extra lag.
      locked_r    <= (state_nxt_s == ST_LOCKED);
      err_early_r <= early_s;
      err_late_r  <= late_s;
      if (period_upd_s) begin
        last_period_r <= cnt_s;
      end else begin
        last_period_r <= last_period_r;
      end
    end
  end

`ifdef EVENT_MON_ERR_COUNT_EN
  logic [ERRCNT_W-1:0] err_count_r;

  // Error total: survives enable low, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= {ERRCNT_W{1'b0}};
    end else if (early_s || late_s) begin
      err_count_r <= errcnt_sat_inc(err_count_r);
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`else
  assign err_count = {ERRCNT_W{1'b0}};
`endif

  assign locked      = locked_r;
  assign err_early   = err_early_r;
  assign err_late    = err_late_r;
  assign last_period = last_period_r;

endmodule

// File: tb/tb_event_pulse_monitor.sv
// -----------------------------------------------------------------------------
// tb_event_pulse_monitor
// Directed bench for event_pulse_monitor (N=10, TOL=0, LOCK_CNT=4, WIDTH=4).
// Each cycle the expected outputs are computed from a behavioural model of the
// monitor and queued when inputs are driven, then popped and compared one
// active edge later. Directed checks against constants cover the key events.
// Expected err_count follows EVENT_MON_ERR_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_event_pulse_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       event_pulse;
  logic       locked;
  logic       err_early;
  logic       err_late;
  logic [3:0] last_period;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       lk;
    logic       ee;
    logic       el;
    logic [3:0] lp;
    logic [7:0] ec;
  } exp_t;

  exp_t sb_q[$];

  // Behavioural model: 0 idle, 1 acquire, 2 track, 3 locked.
  int m_state = 0;
  int m_since = 0;
  int m_good  = 0;
  int m_last  = 0;
  int m_errs  = 0;

  event_pulse_monitor #(
    .N        (10),
    .TOL      (0),
    .LOCK_CNT (4),
    .WIDTH    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .event_pulse (event_pulse),
    .locked      (locked),
    .err_early   (err_early),
    .err_late    (err_late),
    .last_period (last_period),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ec_exp(input int v);
`ifdef EVENT_MON_ERR_COUNT_EN
    return 8'(v);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic en, input logic p);
    exp_t e;
    logic ee;
    logic el;
    ee = 1'b0;
    el = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_since = 0; m_good = 0; m_last = 0; m_errs = 0;
    end else if (!en) begin
      m_state = 0; m_since = 0; m_good = 0;
    end else begin
      case (m_state)
        0: begin
          m_state = 1;
          m_since = 0;
        end
        1: begin
          if (p) begin
            m_since = 1; m_good = 0; m_state = 2;
          end else begin
            m_since = (m_since < 15) ? m_since + 1 : 15;
          end
        end
        default: begin
          if (p) begin
            m_last = m_since;
            if (m_since < 10) begin
              ee = 1'b1; m_good = 0; m_state = 2;
            end else begin
              m_good++;
              if (m_good >= 4) m_state = 3;
            end
            m_since = 1;
          end else if (m_since >= 10) begin
            el = 1'b1;
            m_state = 1;
            m_since = m_since + 1;
          end else begin
            m_since = m_since + 1;
          end
        end
      endcase
    end
    if ((ee || el) && m_errs < 255) m_errs++;
    e.lk = (m_state == 3);
    e.ee = ee;
    e.el = el;
    e.lp = 4'(m_last);
    e.ec = ec_exp(m_errs);
    sb_q.push_back(e);
  endtask

  // One clock: drive at the falling edge, compare just after the rising edge.
  task automatic cyc(input logic en, input logic p);
    exp_t e;
    enable      = en;
    event_pulse = p;
    model_push(en, p);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_locked", 32'(locked), 32'(e.lk));
    chk("sb_err_early", 32'(err_early), 32'(e.ee));
    chk("sb_err_late", 32'(err_late), 32'(e.el));
    chk("sb_last_period", 32'(last_period), 32'(e.lp));
    chk("sb_err_count", 32'(err_count), 32'(e.ec));
    @(negedge clk);
  endtask

  // n-1 quiet cycles then a pulse: pulse lands n cycles after the previous one.
  task automatic gap(input int n);
    repeat (n - 1) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    event_pulse = 1'b0;
    @(negedge clk);

    // Reset held with enable high and pulses toggling: outputs stay 0.
    for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2) == 1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_last_period", 32'(last_period), 32'd0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b1, 1'b0);
    chk("post_rst_no_late", 32'(err_late), 32'd0);

    // Lock: pulses every 10 cycles, lock after the 5th pulse.
    cyc(1'b1, 1'b1);
    repeat (3) gap(10);
    chk("lock_not_yet", 32'(locked), 32'd0);
    gap(10);
    chk("lock_after_5th", 32'(locked), 32'd1);
    chk("lock_period", 32'(last_period), 32'd10);

    // Early pulse at 7 cycles.
    gap(7);
    chk("early_flag", 32'(err_early), 32'd1);
    chk("early_unlock", 32'(locked), 32'd0);
    chk("early_period", 32'(last_period), 32'd7);
    chk("early_count", 32'(err_count), 32'(ec_exp(1)));
    cyc(1'b1, 1'b0);
    chk("early_one_cycle", 32'(err_early), 32'd0);
    gap(9);
    repeat (2) gap(10);
    chk("early_relock_not_yet", 32'(locked), 32'd0);
    gap(10);
    chk("early_relock", 32'(locked), 32'd1);

    // Missing pulse: late flag on the edge where cnt reaches 10.
    repeat (9) cyc(1'b1, 1'b0);
    chk("late_not_yet", 32'(err_late), 32'd0);
    cyc(1'b1, 1'b0);
    chk("late_flag", 32'(err_late), 32'd1);
    chk("late_unlock", 32'(locked), 32'd0);
    chk("late_count", 32'(err_count), 32'(ec_exp(2)));
    cyc(1'b1, 1'b0);
    chk("late_one_cycle", 32'(err_late), 32'd0);
    repeat (2) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("reacq_no_early", 32'(err_early), 32'd0);
    repeat (3) gap(10);
    chk("late_relock_not_yet", 32'(locked), 32'd0);
    gap(10);
    chk("late_relock", 32'(locked), 32'd1);

    // Enable drop with an otherwise-early pulse in the same cycle.
    repeat (6) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("en_drop_unlock", 32'(locked), 32'd0);
    chk("en_drop_no_early", 32'(err_early), 32'd0);
    chk("en_drop_count_kept", 32'(err_count), 32'(ec_exp(2)));
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (4) gap(10);
    chk("en_relock", 32'(locked), 32'd1);

    // 300 early pulses: error total saturates.
    repeat (300) gap(3);
    chk("sat_count", 32'(err_count), 32'(ec_exp(255)));
    chk("sat_flag", 32'(err_early), 32'd1);
    chk("sat_period", 32'(last_period), 32'd3);

    // Asynchronous reset away from any clock edge clears outputs at once.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_early", 32'(err_early), 32'd0);
    chk("async_rst_period", 32'(last_period), 32'd0);
    chk("async_rst_count", 32'(err_count), 32'd0);
    chk("async_rst_locked", 32'(locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_pulse_monitor.md
# event_pulse_monitor

Receive-side checker for the periodic `event_pulse` produced by the mod-N counter integration block. It measures the clock-cycle interval between successive pulses and acquires lock after a run of correctly spaced pulses. Early and late (missing) pulses are reported as one-cycle error flags, and the monitor drops lock on any error. It sits downstream of the pulse generator as a health monitor for the tick distribution.

## Interface
- `N`, default 10: expected pulse period in clk cycles (N ≥ 2).
- `TOL`, default 0: allowed deviation in cycles; a valid period lies in [N−TOL, N+TOL].
- `LOCK_CNT`, default 4: consecutive valid periods needed to assert `locked`.
- `WIDTH`, default 4: interval counter width; requires N+TOL+1 ≤ 2^WIDTH−1.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `enable`, input, 1: monitor enable. Low forces IDLE.
- `event_pulse`, input, 1: one-cycle pulse under test, synchronous to `clk`.
- `locked`, output, 1: period lock indicator.
- `err_early`, output, 1: one-cycle flag for a pulse arriving before N−TOL.
- `err_late`, output, 1: one-cycle flag for no pulse by N+TOL.
- `last_period`, output, WIDTH: most recent measured period.
- `err_count`, output, 8: saturating error total.

## Operation
- Interval counter `cnt`:
  - Loads 1 on the edge that samples a pulse.
  - Otherwise increments, saturating at 2^WIDTH−1.
  - The period is the value of `cnt` at the edge that samples the next pulse, so pulses N cycles apart measure N.
- FSM states: IDLE, ACQUIRE, TRACK, LOCKED.
  - IDLE: `cnt`, good-run counter and `locked` are cleared. `enable`=1 moves to ACQUIRE.
  - ACQUIRE: no interval checks. The first pulse loads `cnt`, clears the good-run counter and moves to TRACK.
  - TRACK and LOCKED, pulse sampled with period in range:
    - `last_period` ← period; good-run counter increments.
    - In TRACK, reaching LOCK_CNT moves to LOCKED.
  - Pulse sampled with period < N−TOL:
    - `err_early` pulses and `last_period` ← period.
    - Good-run counter clears, `cnt` loads 1, next state is TRACK.
  - No pulse and `cnt` == N+TOL:
    - `err_late` pulses; next state is ACQUIRE.
- `locked` = 1 exactly while in LOCKED (registered).
- Simultaneous events:
  - `enable`=0 overrides everything: next state is IDLE and no error flags are raised.
  - A pulse at `cnt` == N+TOL is a valid period, not a late error.
- `err_early` and `err_late` are never asserted in the same cycle.
- `err_count`:
  - Increments by 1 on each error flag and saturates at 255.
  - Kept across `enable` low; cleared only by reset.

## Timing
- All outputs are registered. Reset value of every output is 0; FSM resets to IDLE.
- Latency: a pulse sampled at edge E updates `last_period`, `err_early` and `locked` in the cycle following E.
- `err_late` is asserted in the cycle following the edge where `cnt` == N+TOL with no pulse.
- Error flags are high for exactly one cycle.
- `enable` falling at edge E: `locked` is 0 from the cycle after E.
- `rst_n` asserted mid-operation clears all state and outputs immediately, asynchronously. Release is synchronous to the next `clk` edge.

## Configuration
- Macro: `EVENT_MON_ERR_COUNT_EN`.
- Defined: `err_count` is implemented as described.
- Undefined: the counter is not built and `err_count` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `event_mon_pkg`:
  - state typedef (IDLE, ACQUIRE, TRACK, LOCKED);
  - constant `ERRCNT_W` = 8.
- Sub-module `event_interval_counter`: WIDTH-bit saturating up-counter with synchronous load-1, used for `cnt`.
- FSM, checks and error counter live in the top level.

## Test plan
All scenarios use N=10, TOL=0, LOCK_CNT=4, WIDTH=4.
- **Reset:** `rst_n`=0 with `enable`=1 and pulses toggling → all outputs 0 throughout. Once released, no flags until the first pulse.
- **Lock:** pulses every 10 cycles → `locked` rises the cycle after the 5th pulse; `last_period`=10; no error flags.
- **Early pulse:** while locked, a pulse 7 cycles after the previous one → `err_early`=1 for one cycle, `locked`=0, `last_period`=7, `err_count`=1. Relock occurs after 4 further 10-cycle periods.
- **Missing pulse:** while locked, a pulse is omitted → `err_late`=1 one cycle after `cnt` reaches 10, `locked`=0, `err_count` increments. The next pulse only re-acquires; lock follows after 4 more good periods.
- **Enable drop:** `enable` deasserted while locked → `locked`=0 next cycle, `err_count` retained. A pulse in the same cycle produces no flag.
- **Saturation and macro:** inject 300 early pulses → `err_count` holds 255. With `EVENT_MON_ERR_COUNT_EN` undefined, `err_count` stays 0 while the error flags still pulse.
